// File: rtl/mybus_pkg.sv
// Shared MYBUS definitions used by the line write engine and its sibling engines.
//   TAG_W          width of the bus request tag
//   WRITE_MEM_TAG  tag driven while a write-memory beat is on the bus
//   mem_wr_state_e write engine state encoding
package mybus_pkg;

  localparam int unsigned TAG_W = 4;

  localparam logic [TAG_W-1:0] WRITE_MEM_TAG = 4'h2;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } mem_wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping
// around. Purely combinational; the caller owns and advances the pointer.
//   req        request vector
//   ptr        highest-priority index for this cycle (must be < N)
//   grant      one-hot grant (zero when no request)
//   grant_idx  binary index of the granted request
//   any_req    at least one request asserted
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any_req
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[IDXW'(idx)]) begin
        found              = 1'b1;
        grant[IDXW'(idx)]  = 1'b1;
        grant_idx          = IDXW'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_line_write_engine.sv
// Multi-channel cache-line write-back engine. Accepts line write requests from
// NUM_CH clients (round-robin) and serialises each onto the shared bus as one
// address beat followed by len data beats, each beat held until bus_reqack.
//   clk, reset   clock, synchronous active-high reset
//   req_valid    per-client line write request
//   req_addr     per-client line address (ADDR_BITS each)
//   req_data     per-client line data, beat k at [k*BEAT_BITS +: BEAT_BITS]
//   req_len      per-client beat count, 0 means a full line
//   req_ready    one-hot pulse, request accepted this cycle
//   req_done     one-hot pulse, all beats of that client's write accepted
//   bus_bid      bus ownership bid
//   bus_reqcyc   beat valid on bus_req
//   bus_reqtag   write-memory tag while bus_reqcyc is high
//   bus_req      address or data beat
//   bus_reqack   bus accepted the current beat
//   bus_respack  tied low, writes carry no response
module mem_line_write_engine
  import mybus_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned LINE_BITS = 512,
  parameter int unsigned BEAT_BITS = 64,
  parameter int unsigned ADDR_BITS = 64,
  localparam int unsigned BEATS    = LINE_BITS / BEAT_BITS,
  localparam int unsigned LENW     = $clog2(BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*ADDR_BITS-1:0] req_addr,
  input  logic [NUM_CH*LINE_BITS-1:0] req_data,
  input  logic [NUM_CH*LENW-1:0]      req_len,
  output logic [NUM_CH-1:0]           req_ready,
  output logic [NUM_CH-1:0]           req_done,
  output logic                        bus_bid,
  output logic                        bus_reqcyc,
  output logic [TAG_W-1:0]            bus_reqtag,
  output logic [BEAT_BITS-1:0]        bus_req,
  input  logic                        bus_reqack,
  output logic                        bus_respack
);

  localparam int unsigned CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BIDX = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NUM_CH < 1) begin : g_bad_ch
    $error("NUM_CH must be at least 1");
  end
  if ((LINE_BITS % BEAT_BITS) != 0) begin : g_bad_beat
    $error("LINE_BITS must be a multiple of BEAT_BITS");
  end

  mem_wr_state_e                   state_q;
  logic [CHW-1:0]                  rr_ptr_q;
  logic [CHW-1:0]                  grant_idx_q;
  logic [LENW-1:0]                 len_q;
  logic [LENW-1:0]                 beat_cnt_q;
  logic [BEATS-1:0][BEAT_BITS-1:0] line_buf_q;

  logic                 bus_bid_q;
  logic                 bus_reqcyc_q;
  logic [TAG_W-1:0]     bus_reqtag_q;
  logic [BEAT_BITS-1:0] bus_req_q;
  logic [NUM_CH-1:0]    req_done_q;

  logic [NUM_CH-1:0]    grant;
  logic [CHW-1:0]       grant_idx;
  logic                 any_req;

  logic [ADDR_BITS-1:0] sel_addr;
  logic [LINE_BITS-1:0] sel_data;
  logic [LENW-1:0]      sel_len;
  logic [LENW-1:0]      sel_len_eff;
  logic [CHW-1:0]       rr_ptr_nxt;
  logic [LENW-1:0]      beat_nxt;
  logic                 last_beat;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Selected client's request fields, used only when latching in idle.
  always_comb begin
    sel_addr    = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
    sel_data    = req_data[grant_idx*LINE_BITS +: LINE_BITS];
    sel_len     = req_len[grant_idx*LENW +: LENW];
    sel_len_eff = (sel_len == '0) ? LENW'(BEATS) : sel_len;
    rr_ptr_nxt  = (grant_idx == CHW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    beat_nxt    = beat_cnt_q + 1'b1;
    last_beat   = (beat_cnt_q == len_q - 1'b1);
  end

  // Bus outputs are registered and loaded one cycle ahead, so the beat on the
  // bus in the data state always equals line_buf_q[beat_cnt_q].
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      bus_bid_q    <= 1'b0;
      bus_reqcyc_q <= 1'b0;
      bus_reqtag_q <= '0;
      bus_req_q    <= '0;
      req_done_q   <= '0;
    end else begin
      req_done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            line_buf_q   <= sel_data;
            len_q        <= sel_len_eff;
            grant_idx_q  <= grant_idx;
            rr_ptr_q     <= rr_ptr_nxt;
            beat_cnt_q   <= '0;
            bus_bid_q    <= 1'b1;
            bus_reqcyc_q <= 1'b1;
            bus_reqtag_q <= WRITE_MEM_TAG;
            bus_req_q    <= BEAT_BITS'(sel_addr);
            state_q      <= StAddr;
          end
        end
        StAddr: begin
          if (bus_reqack) begin
            bus_req_q <= line_buf_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (bus_reqack) begin
            if (last_beat) begin
              bus_bid_q    <= 1'b0;
              bus_reqcyc_q <= 1'b0;
              bus_reqtag_q <= '0;
              bus_req_q    <= '0;
              req_done_q   <= NUM_CH'(1) << grant_idx_q;
              state_q      <= StDone;
            end else begin
              beat_cnt_q <= beat_nxt;
              bus_req_q  <= line_buf_q[BIDX'(beat_nxt)];
            end
          end
        end
        StDone: begin
          beat_cnt_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Acceptance is the only same-cycle response; it is suppressed under reset.
  assign req_ready   = ((state_q == StIdle) && !reset) ? grant : '0;
  assign req_done    = req_done_q;
  assign bus_bid     = bus_bid_q;
  assign bus_reqcyc  = bus_reqcyc_q;
  assign bus_reqtag  = bus_reqtag_q;
  assign bus_req     = bus_req_q;
  assign bus_respack = 1'b0;

endmodule
